// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM state codes, word-length encodings and helpers.
package uart_pkg;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t TX_IDLE   = 3'd0;
  localparam tx_state_t TX_START  = 3'd1;
  localparam tx_state_t TX_DATA   = 3'd2;
  localparam tx_state_t TX_PARITY = 3'd3;
  localparam tx_state_t TX_STOP   = 3'd4;
  localparam tx_state_t TX_BREAK  = 3'd5;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  function automatic logic [3:0] wls_to_bits(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

endpackage

// File: rtl/uart_transmit_fsm_if.sv
// TX FIFO read port: head word and empty flag towards the framer, single-cycle pop back.
interface uart_transmit_fsm_if #(parameter int DATA_W = 8);
  logic              tx_fifo_empty;
  logic [DATA_W-1:0] tx_data;
  logic              tx_fifo_rd_en;

  modport master (output tx_fifo_empty, output tx_data, input tx_fifo_rd_en);
  modport slave  (input tx_fifo_empty, input tx_data, output tx_fifo_rd_en);
endinterface

// File: rtl/dff.sv
// Generic resettable register bank; one cycle of latency, no flow control.
module dff #(
  parameter int                    FLOP_WIDTH  = 1,
  parameter logic [FLOP_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLOP_WIDTH-1:0] d,
  output logic [FLOP_WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RESET_VALUE;
    else        q <= d;
  end
endmodule

// File: rtl/uart_tx_shifter.sv
// Data path of the transmitter: masked shift register, bit counter and parity of the latched word.
// Loads on load_i, shifts one bit per shift_i; no backpressure.
module uart_tx_shifter
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        wls_i,
  input  logic              eps_i,
  output logic              cur_bit_o,
  output logic              next_bit_o,
  output logic              parity_o,
  output logic              last_bit_o
);
  logic [DATA_W-1:0] shift_q, shift_d, mask, masked;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        wls_q, wls_d;
  logic              par_q, par_d;

  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_W; i++) mask[i] = (i < int'(wls_to_bits(wls_i)));
    masked = data_i & mask;
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    wls_d   = wls_q;
    par_d   = par_q;
    if (load_i) begin
      shift_d = masked;
      cnt_d   = 3'd0;
      wls_d   = wls_i;
      // eps=1 selects even parity: the parity bit makes the total count of ones even
      par_d   = eps_i ? ^masked : ~^masked;
    end else if (shift_i) begin
      shift_d = shift_q >> 1;
      cnt_d   = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      shift_q <= '0;
      cnt_q   <= '0;
      wls_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      wls_q   <= wls_d;
      par_q   <= par_d;
    end
  end

  assign cur_bit_o  = shift_q[0];
  assign next_bit_o = shift_q[1];
  assign parity_o   = par_q;
  assign last_bit_o = (cnt_q == 3'(wls_to_bits(wls_q) - 4'd1));
endmodule

// File: rtl/uart_transmit_fsm.sv
// UART transmit framer: start, 5-8 data bits LSB first, optional parity, 1-2 stops, plus line break.
// Advances one bit per tx_edge; pops the FIFO only when a new frame can start on that edge.
module uart_transmit_fsm
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      utrst,
  input  logic                      tx_edge,
  input  logic [1:0]                wls,
  input  logic                      stb,
  input  logic                      pen,
  input  logic                      eps,
  input  logic                      bc,
  uart_transmit_fsm_if.slave        txf,
  output logic                      uart_txd,
  output logic                      tx_busy,
  output logic                      tx_done
);
  tx_state_t state_q, state_d;
  logic      txd_q, txd_d;
  logic      stop_cnt_q, stop_cnt_d;
  logic      stb_q, pen_q;
  logic      frame_end, load, shift, done;
  logic      cur_bit, next_bit, parity, last_bit;

  assign frame_end = (state_q == TX_STOP) && (stop_cnt_q == stb_q);
  assign load  = tx_edge & utrst & ~txf.tx_fifo_empty & ~bc & ((state_q == TX_IDLE) | frame_end);
  assign shift = tx_edge & utrst & (state_q == TX_DATA) & ~last_bit;

  uart_tx_shifter #(.DATA_W(DATA_W)) u_shifter (
    .pclk       (pclk),
    .presetn    (presetn),
    .load_i     (load),
    .shift_i    (shift),
    .data_i     (txf.tx_data),
    .wls_i      (wls),
    .eps_i      (eps),
    .cur_bit_o  (cur_bit),
    .next_bit_o (next_bit),
    .parity_o   (parity),
    .last_bit_o (last_bit)
  );

  always_comb begin
    state_d    = state_q;
    txd_d      = txd_q;
    stop_cnt_d = stop_cnt_q;
    done       = 1'b0;
    if (!utrst) begin
      state_d    = TX_IDLE;
      txd_d      = 1'b1;
      stop_cnt_d = 1'b0;
    end else if (tx_edge) begin
      case (state_q)
        TX_IDLE: begin
          if (bc)        begin state_d = TX_BREAK; txd_d = 1'b0; end
          else if (load) begin state_d = TX_START; txd_d = 1'b0; end
        end
        TX_START: begin
          state_d = TX_DATA;
          txd_d   = cur_bit;
        end
        TX_DATA: begin
          // next_bit is what lands in bit 0 after this edge's shift
          if (!last_bit)  txd_d = next_bit;
          else if (pen_q) begin state_d = TX_PARITY; txd_d = parity; end
          else            begin state_d = TX_STOP; txd_d = 1'b1; stop_cnt_d = 1'b0; end
        end
        TX_PARITY: begin
          state_d    = TX_STOP;
          txd_d      = 1'b1;
          stop_cnt_d = 1'b0;
        end
        TX_STOP: begin
          if (frame_end) begin
            done = 1'b1;
            if (load)    begin state_d = TX_START; txd_d = 1'b0; end
            else if (bc) begin state_d = TX_BREAK; txd_d = 1'b0; end
            else         begin state_d = TX_IDLE;  txd_d = 1'b1; end
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
        TX_BREAK: begin
          if (!bc) begin state_d = TX_IDLE; txd_d = 1'b1; end
        end
        default: begin
          state_d = TX_IDLE;
          txd_d   = 1'b1;
        end
      endcase
    end
  end

  dff #(.FLOP_WIDTH(3), .RESET_VALUE(TX_IDLE)) u_state (
    .clk   (pclk),
    .rst_n (presetn),
    .d     (state_d),
    .q     (state_q)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      txd_q      <= 1'b1;
      stop_cnt_q <= 1'b0;
      stb_q      <= 1'b0;
      pen_q      <= 1'b0;
    end else begin
      txd_q      <= txd_d;
      stop_cnt_q <= stop_cnt_d;
      if (load) begin
        stb_q <= stb;
        pen_q <= pen;
      end
    end
  end

  assign txf.tx_fifo_rd_en = load;
  assign uart_txd          = txd_q;
  assign tx_busy           = (state_q != TX_IDLE);
  assign tx_done           = done;
endmodule

// File: doc/uart_transmit_fsm.md
Name: uart_transmit_fsm

Overview:
- Transmit-side framing engine of the UART; counterpart of the receive FSM.
- Pops bytes from the TX FIFO and serialises them onto uart_txd: start bit, 5-8 data bits LSB first, optional parity, then 1 or 2 stop bits.
- Also generates line break.
- Bit timing comes from an external baud generator as a one-pclk tx_edge pulse per bit period.

Parameters:
- DATA_W, 8, TX FIFO data width; also the maximum word length.

Ports:
- pclk  in  1  APB/UART clock
- presetn  in  1  reset; asynchronous, active-low
- utrst  in  1  transmit enable; 0 aborts the frame and holds the line idle
- tx_edge  in  1  one-cycle pulse, one per bit period
- tx_fifo_empty  in  1  TX FIFO empty flag
- tx_data  in  DATA_W  FIFO head word, valid when not empty
- wls  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits
- stb  in  1  0=1 stop bit, 1=2 stop bits
- pen  in  1  parity enable
- eps  in  1  1=even parity, 0=odd parity
- bc  in  1  break control
- uart_txd  out  1  serial output, idle high
- tx_fifo_rd_en  out  1  one-cycle FIFO pop
- tx_busy  out  1  high in any state other than IDLE
- tx_done  out  1  one-cycle pulse at completion of a frame

Behaviour:
- Reset (async, presetn=0):
  - state=IDLE, uart_txd=1, tx_fifo_rd_en=0, tx_busy=0, tx_done=0.
  - Shift register, bit counter and latched config all cleared.
- States: IDLE, START, DATA, PARITY, STOP, BREAK (3-bit encoding).
- Transitions happen only on pclk edges where tx_edge=1, except the utrst abort.
- uart_txd is a flop loaded from the next-state value, so it changes on the same edge as the state register.
- Load condition: tx_edge & utrst & ~tx_fifo_empty & ~bc & (state==IDLE | last stop bit).
  - On load: tx_fifo_rd_en=1 for that cycle.
  - tx_data, wls, stb, pen, eps are latched.
  - Parity bit computed from the masked data: eps ? ^data : ~^data.
  - Next state START, txd=0.
  - Config changes mid-frame have no effect.
- START: at tx_edge -> DATA; txd = shift[0].
- DATA: at each tx_edge, shift right and increment the bit counter.
  - After bit count = wls+5: -> PARITY if pen, else STOP.
- PARITY: txd = latched parity bit; at tx_edge -> STOP.
- STOP: txd=1; stop counter 0..stb.
  - At tx_edge on the last stop bit: tx_done=1 for one cycle.
  - If the load condition holds: -> START (back-to-back frames, no idle gap).
  - Else if bc & utrst: -> BREAK.
  - Else: -> IDLE.
- IDLE: if bc & utrst at tx_edge -> BREAK; otherwise load if possible.
- BREAK: txd=0; at tx_edge with bc=0 -> IDLE (txd=1).
- bc asserted mid-frame: the current frame completes normally, then BREAK.
- utrst=0 in any state: next edge -> IDLE, txd=1, no tx_done, no pop. The frame being sent is lost (already popped).
- tx_edge with FIFO empty in IDLE: stay IDLE, no pop.
- tx_done and tx_fifo_rd_en can assert in the same cycle (back-to-back).
- Bit period: every bit lasts exactly one tx_edge interval, because the start is aligned to tx_edge.

Decomposition:
- uart_pkg holds:
  - tx state enum
  - WLS_5/6/7/8 encodings
  - function wls_to_bits(wls) returning 5..8
- Sub-module uart_tx_shifter: DATA_W shift register, 3-bit data counter, parity generator, last-bit flag.
- State register uses the existing dff (FLOP_WIDTH=3), reset to IDLE.

Test Plan:
- Reset values: presetn low mid-frame -> uart_txd=1, busy=0, state IDLE immediately (asynchronous).
- 8N1: wls=11, pen=0, stb=0, tx_data=0xA5, tx_edge every 16 pclk -> txd sequence 0,1,0,1,0,0,1,0,1,1 (10 bits × 16 cycles); one rd_en; tx_done at the final edge.
- 7E2: wls=10, pen=1, eps=1, stb=1, data=0x03 -> bits 0,1,1,0,0,0,0,0, parity 0, stop 1,1; then 7O2 with same data -> parity 1.
- Back-to-back: FIFO holds 0x55, 0x0F -> second start bit immediately follows the first stop bit; rd_en and tx_done coincide; 20 bit times in total.
- Break: bc=1 during byte 0x81 -> frame completes, txd low until bc=0, then IDLE one tx_edge later.
- Abort: utrst dropped during the 3rd data bit -> txd=1 next cycle, no tx_done; next frame starts cleanly after utrst=1.
